lp_filter_multi: RTL and testbench

LP_FILTER_MULTI -- requirements
Module: lp_filter_multi

---
 rtl/lp_filter_multi.sv | 152 +++++++++++++++
 tb/tb_lp_filter_multi.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_filter_multi.sv
// Multi-channel cascaded first-order low-pass filter sharing one stage-update datapath.
// Latency: out_vld pulses CH*ORDER+1 cycles after the accepted in_vld strobe.
// No backpressure: strobes arriving while busy are dropped and latch the sticky miss flag.
module lp_filter_multi #(
   parameter int R     = 14,
   parameter int RT    = 6,
   parameter int CH    = 4,
   parameter int ORDER = 2,
   parameter int S     = 49
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clr,
   input  logic            in_vld,
   input  logic [CH*R-1:0] in_data,
   input  logic [CH*RT-1:0] tau,
   output logic [CH*R-1:0] out_data,
   output logic            out_vld,
   output logic            busy,
   output logic            miss
);

   localparam int N    = CH * ORDER;
   localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
   localparam int SW   = (ORDER > 1) ? $clog2(ORDER) : 1;
   localparam int IW   = (N > 1) ? $clog2(N) : 1;
   localparam int TMAX = S - R;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;

   logic [CH*R-1:0]     cap_data;
   logic [CH*RT-1:0]    cap_tau;
   logic [CW-1:0]       ch_idx;
   logic [SW-1:0]       st_idx;
   logic signed [S-1:0] acc [N];
   logic signed [R-1:0] prev_out;
   logic [CH*R-1:0]     res;

   logic [IW-1:0]       idx;
   logic [RT-1:0]       tau_c;
   logic [31:0]         t_eff;
   logic signed [R-1:0] x_in;
   logic signed [S-1:0] acc_cur;
   logic signed [S-1:0] shr;
   logic [S:0]          sum_n;
   logic signed [S-1:0] acc_new;
   logic signed [S-1:0] so;
   logic                fits;
   logic signed [R-1:0] stg_out;
   logic                last_stage;
   logic                last_step;
   logic [CH*R-1:0]     res_nxt;

   // Shared stage update for the (channel, stage) slot selected by the sweep counters
   always_comb begin
      idx        = IW'(ch_idx) * IW'(ORDER) + IW'(st_idx);
      tau_c      = cap_tau[ch_idx*RT +: RT];
      t_eff      = (32'(tau_c) > 32'(TMAX)) ? 32'(TMAX) : 32'(tau_c);
      last_stage = (st_idx == SW'(ORDER - 1));
      last_step  = last_stage && (ch_idx == CW'(CH - 1));
      // stage 0 reads the captured sample, later stages chain the previous stage output
      x_in       = (st_idx == '0) ? cap_data[ch_idx*R +: R] : prev_out;
      acc_cur    = acc[idx];
      shr        = acc_cur >>> t_eff;
      sum_n      = {{(S+1-R){x_in[R-1]}}, x_in} - {shr[S-1], shr} + {acc_cur[S-1], acc_cur};
      if (sum_n[S] != sum_n[S-1])
         acc_new = sum_n[S] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
      else
         acc_new = sum_n[S-1:0];
      so         = acc_new >>> t_eff;
      fits       = (&so[S-1:R-1]) | (~|so[S-1:R-1]);
      if (fits)
         stg_out = so[R-1:0];
      else
         stg_out = so[S-1] ? {1'b1, {(R-1){1'b0}}} : {1'b0, {(R-1){1'b1}}};
      res_nxt    = res;
      if (last_stage)
         res_nxt[ch_idx*R +: R] = stg_out;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic; clr aborts any sweep back to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_vld) state_nxt = RUN;
         RUN:     if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (clr)
         state_nxt = IDLE;
   end

   // Status outputs decoded from state
   always_comb begin
      busy    = (state != IDLE);
      out_vld = (state == DONE);
   end

   // Capture, accumulator updates, sweep counters, result publishing and miss flag
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N; i++) acc[i] <= '0;
         cap_data <= '0;
         cap_tau  <= '0;
         ch_idx   <= '0;
         st_idx   <= '0;
         prev_out <= '0;
         res      <= '0;
         out_data <= '0;
         miss     <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < N; i++) acc[i] <= '0;
         ch_idx <= '0;
         st_idx <= '0;
         miss   <= 1'b0;
      end else begin
         if (in_vld && busy)
            miss <= 1'b1;
         if (state == IDLE && in_vld) begin
            cap_data <= in_data;
            cap_tau  <= tau;
            ch_idx   <= '0;
            st_idx   <= '0;
         end
         if (state == RUN) begin
            acc[idx] <= acc_new;
            prev_out <= stg_out;
            res      <= res_nxt;
            if (last_stage) begin
               st_idx <= '0;
               ch_idx <= ch_idx + 1'b1;
            end else begin
               st_idx <= st_idx + 1'b1;
            end
            // all channels become visible together in the DONE cycle
            if (last_step)
               out_data <= res_nxt;
         end
      end
   end

endmodule

// File: tb/tb_lp_filter_multi.sv
// Bench for lp_filter_multi: directed sweeps checked against a behavioural filter model.
// Latency: every accepted sample is expected to produce out_vld exactly CH*ORDER+1 cycles later.
// Backpressure: overlapping strobes, clr and rst aborts are exercised and must not emit outputs.
module tb_lp_filter_multi;
   localparam int R = 14, RT = 6, CH = 4, ORDER = 2, S = 49;
   localparam longint SMAX = (64'sd1 <<< (S-1)) - 1;
   localparam longint SMIN = -(64'sd1 <<< (S-1));
   localparam longint RMAX = (64'sd1 <<< (R-1)) - 1;
   localparam longint RMIN = -(64'sd1 <<< (R-1));

   logic             clk = 1'b0;
   logic             rst, clr, in_vld;
   logic [CH*R-1:0]  in_data;
   logic [CH*RT-1:0] tau;
   logic [CH*R-1:0]  out_data;
   logic             out_vld, busy, miss;

   int checks = 0;
   int errors = 0;

   longint          macc [CH][ORDER];
   logic [CH*R-1:0] exp_q [$];
   logic [CH*R-1:0] exp_out;
   logic [CH*R-1:0] got;
   longint          arr63 [200];

   lp_filter_multi #(.R(R), .RT(RT), .CH(CH), .ORDER(ORDER), .S(S)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_data(in_data),
      .tau(tau), .out_data(out_data), .out_vld(out_vld), .busy(busy), .miss(miss)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, expv);
      end
   endtask

   function automatic longint fld(input logic [CH*R-1:0] v, input int c);
      return longint'($signed(v[c*R +: R]));
   endfunction

   function automatic logic [CH*R-1:0] pk(input int a0, input int a1, input int a2, input int a3);
      logic [CH*R-1:0] v;
      v = '0;
      v[0*R +: R] = a0[R-1:0];
      v[1*R +: R] = a1[R-1:0];
      v[2*R +: R] = a2[R-1:0];
      v[3*R +: R] = a3[R-1:0];
      return v;
   endfunction

   function automatic logic [CH*RT-1:0] tk(input int t0, input int t1, input int t2, input int t3);
      logic [CH*RT-1:0] v;
      v = '0;
      v[0*RT +: RT] = t0[RT-1:0];
      v[1*RT +: RT] = t1[RT-1:0];
      v[2*RT +: RT] = t2[RT-1:0];
      v[3*RT +: RT] = t3[RT-1:0];
      return v;
   endfunction

   function automatic void model_clear();
      for (int c = 0; c < CH; c++)
         for (int k = 0; k < ORDER; k++) macc[c][k] = 0;
   endfunction

   // One full sample through every channel's cascade, in plain integer arithmetic
   function automatic void model_step(input logic [CH*R-1:0] d, input logic [CH*RT-1:0] tv,
                                      output logic [CH*R-1:0] o);
      longint x, s, y;
      int t;
      o = '0;
      for (int c = 0; c < CH; c++) begin
         t = int'(tv[c*RT +: RT]);
         if (t > S - R) t = S - R;
         x = longint'($signed(d[c*R +: R]));
         y = 0;
         for (int k = 0; k < ORDER; k++) begin
            s = x - (macc[c][k] >>> t) + macc[c][k];
            if (s > SMAX) s = SMAX;
            if (s < SMIN) s = SMIN;
            macc[c][k] = s;
            y = s >>> t;
            if (y > RMAX) y = RMAX;
            if (y < RMIN) y = RMIN;
            x = y;
         end
         o[c*R +: R] = y[R-1:0];
      end
   endfunction

   // Per-cycle compare: outputs on out_vld match the model, otherwise out_data holds
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_out = '0;
      end else if (out_vld) begin
         if (exp_q.size() == 0) begin
            chk("unexpected out_vld", 1, 0);
         end else begin
            exp_out = exp_q.pop_front();
            for (int c = 0; c < CH; c++)
               chk($sformatf("model out ch%0d", c), fld(out_data, c), fld(exp_out, c));
         end
      end else begin
         chk("out_data hold", longint'(out_data), longint'(exp_out));
      end
   end

   // Drive one sample; optionally a second strobe at offset extra_at; scramble inputs mid-sweep
   task automatic send(input logic [CH*R-1:0] d, input logic [CH*RT-1:0] tv,
                       input int extra_at, output logic [CH*R-1:0] res);
      logic [CH*R-1:0] e;
      int n;
      bit seen;
      @(negedge clk);
      in_data = d;
      tau     = tv;
      in_vld  = 1'b1;
      model_step(d, tv, e);
      exp_q.push_back(e);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         in_vld = (n == extra_at);
         if (n == 1) begin
            chk("busy after capture", busy, 1);
            in_data = ~d;
            tau     = ~tv;
         end
         if (out_vld) seen = 1'b1;
      end
      if (seen) chk("latency", n, CH*ORDER + 1);
      else      chk("out_vld timeout", 0, 1);
      chk("busy in DONE", busy, 1);
      res = out_data;
      in_vld = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_clear();
   endtask

   // Start a sweep and kill it four cycles after capture with rst (use_rst) or clr
   task automatic abort_sweep(input bit use_rst);
      @(negedge clk);
      in_data = pk(4000, 4000, 4000, 4000);
      tau     = tk(0, 0, 0, 0);
      in_vld  = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         in_vld = 1'b0;
      end
      if (use_rst) rst = 1'b1;
      else         clr = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      clr = 1'b0;
      model_clear();
      repeat (14) @(negedge clk);
      chk("busy after abort", busy, 0);
      chk("miss after abort", miss, 0);
      if (use_rst) chk("out_data after rst", longint'(out_data), 0);
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

   // Directed sequence
   initial begin
      rst = 1'b1; clr = 1'b0; in_vld = 1'b0; in_data = '0; tau = '0;
      model_clear();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset out_data", longint'(out_data), 0);
      chk("reset out_vld", out_vld, 0);
      chk("reset busy", busy, 0);
      chk("reset miss", miss, 0);

      // pass-through with tau = 0
      send(pk(1000, -500, 0, 0), tk(0, 0, 0, 0), 0, got);
      chk("pass ch0", fld(got, 0), 1000);
      chk("pass ch1", fld(got, 1), -500);
      chk("pass ch2", fld(got, 2), 0);
      chk("pass ch3", fld(got, 3), 0);
      @(negedge clk);
      chk("idle after DONE", busy, 0);
      chk("no miss on clean run", miss, 0);

      // cascade step response, tau_0 = 4
      pulse_clr();
      send(pk(1000, 0, 0, 0), tk(4, 0, 0, 0), 0, got);
      chk("cascade first output", fld(got, 0), 3);
      for (int i = 1; i < 500; i++) send(pk(1000, 0, 0, 0), tk(4, 0, 0, 0), 0, got);
      chk("cascade settled", fld(got, 0), 1000);

      // tau clamp: 63 behaves like 35
      pulse_clr();
      for (int i = 0; i < 200; i++) begin
         send(pk(-8192 + 80*i, 8191, -3000, 77), tk(63, 20, 3, 63), 0, got);
         arr63[i] = fld(got, 0);
      end
      pulse_clr();
      for (int i = 0; i < 200; i++) begin
         send(pk(-8192 + 80*i, 8191, -3000, 77), tk(35, 20, 3, 63), 0, got);
         chk($sformatf("clamp sample %0d", i), fld(got, 0), arr63[i]);
      end

      // dropped strobe at T+3, then clr restores a zero state
      pulse_clr();
      send(pk(1000, 0, 0, 0), tk(4, 0, 0, 0), 3, got);
      chk("drop first output", fld(got, 0), 3);
      repeat (12) @(negedge clk);
      chk("miss set by drop", miss, 1);
      pulse_clr();
      chk("miss cleared", miss, 0);
      send(pk(1000, 0, 0, 0), tk(4, 0, 0, 0), 0, got);
      chk("post-clr from zero", fld(got, 0), 3);

      // mid-sweep clr
      abort_sweep(1'b0);
      send(pk(1234, -77, 5, -8192), tk(0, 0, 0, 0), 0, got);
      chk("after clr ch0", fld(got, 0), 1234);
      chk("after clr ch1", fld(got, 1), -77);
      chk("after clr ch3", fld(got, 3), -8192);

      // mid-sweep rst
      abort_sweep(1'b1);
      send(pk(-4321, 8191, 0, 12), tk(0, 0, 0, 0), 0, got);
      chk("after rst ch0", fld(got, 0), -4321);
      chk("after rst ch1", fld(got, 1), 8191);
      chk("after rst ch3", fld(got, 3), 12);
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
